// File: rtl/time_set_editor_pkg.sv
// Shared types, digit limits and helpers for the MM:SS time-set editor.
package time_set_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EDIT   = 2'd1,
        COMMIT = 2'd2
    } state_e;

    // Upper limit of each BCD digit of MM:SS
    localparam logic [3:0] MIN_TENS_MAX  = 4'd5;
    localparam logic [3:0] MIN_UNITS_MAX = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX  = 4'd5;
    localparam logic [3:0] SEC_UNITS_MAX = 4'd9;

    localparam logic [3:0] SEL_LEFTMOST = 4'b1000;

    // Bit positions of the buttons in the packed pulse vector
    localparam int BTN_U = 3;
    localparam int BTN_D = 2;
    localparam int BTN_L = 1;
    localparam int BTN_R = 0;

    typedef enum logic [2:0] {
        ACT_NONE  = 3'd0,
        ACT_UP    = 3'd1,
        ACT_DOWN  = 3'd2,
        ACT_LEFT  = 3'd3,
        ACT_RIGHT = 3'd4
    } action_e;

    // Only one action per cycle: up > down > left > right, the rest dropped
    function automatic action_e pick_action(input logic [3:0] p);
        if (p[BTN_U]) return ACT_UP;
        if (p[BTN_D]) return ACT_DOWN;
        if (p[BTN_L]) return ACT_LEFT;
        if (p[BTN_R]) return ACT_RIGHT;
        return ACT_NONE;
    endfunction

    function automatic logic [3:0] digit_max(input int idx);
        case (idx)
            3:       return MIN_TENS_MAX;
            2:       return MIN_UNITS_MAX;
            1:       return SEC_TENS_MAX;
            default: return SEC_UNITS_MAX;
        endcase
    endfunction

    // Step the selected nibble up or down with wrap; no carry/borrow.
    // Out-of-range digits go to 0 on up and to the limit on down.
    function automatic logic [15:0] bump_digit(input logic [15:0] v,
                                               input logic [3:0]  sel,
                                               input logic        up);
        logic [15:0] r;
        logic [3:0]  d;
        logic [3:0]  lim;
        r = v;
        for (int i = 0; i < 4; i++) begin
            d   = v[i*4 +: 4];
            lim = digit_max(i);
            if (sel[i]) begin
                if (up) r[i*4 +: 4] = (d >= lim) ? 4'd0 : d + 4'd1;
                else    r[i*4 +: 4] = (d == 4'd0 || d > lim) ? lim : d - 4'd1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/time_set_editor_button_edge.sv
// One push button: 2-flop synchronizer, optional debounce, rising-edge pulse.
// Debounce is built only when TIME_SET_DEBOUNCE_EN is defined.
module button_edge #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic pulse_o
);

    logic s1_q, s1_d, s2_q, s2_d;
    logic lvl;
    logic lvl_prev_q, lvl_prev_d;

    // Next values for the synchronizer and edge-detect history
    always_comb begin
        s1_d       = btn_i;
        s2_d       = s1_q;
        lvl_prev_d = lvl;
    end

    // Synchronizer and previous-level register
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            lvl_prev_q <= 1'b0;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            lvl_prev_q <= lvl_prev_d;
        end
    end

`ifdef TIME_SET_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          db_q, db_d;

    // Count consecutive samples differing from the accepted level; flip on the Nth
    always_comb begin
        cnt_d = cnt_q;
        db_d  = db_q;
        if (s2_q == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            db_d  = s2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Debounce state
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            db_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            db_q  <= db_d;
        end
    end

    assign lvl = db_q;
`else
    logic [31:0] unused_debounce;
    assign unused_debounce = 32'(DEBOUNCE_CYCLES);
    assign lvl = s2_q;
`endif

    assign pulse_o = lvl & ~lvl_prev_q;

endmodule

// File: rtl/time_set_editor.sv
// MM:SS BCD entry stage: buttons edit a 4-digit value while spdt1 is on,
// a one-cycle finish1 commits it when spdt1 goes off.
// Optional button debounce: define TIME_SET_DEBOUNCE_EN.
module time_set_editor
    import time_set_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        spdt1,
    input  logic [15:0] preset,
    input  logic        push_u,
    input  logic        push_d,
    input  logic        push_l,
    input  logic        push_r,
    output logic [15:0] num,
    output logic [3:0]  sel,
    output logic        finish1
);

    logic [3:0] btn_raw;
    logic [3:0] btn_pulse;

    assign btn_raw = {push_u, push_d, push_l, push_r};

    button_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn [3:0] (
        .clk     (clk),
        .reset   (reset),
        .btn_i   (btn_raw),
        .pulse_o (btn_pulse)
    );

    state_e      state_q, state_d;
    logic [15:0] num_q, num_d;
    logic [3:0]  sel_q, sel_d;
    logic        spdt_s1_q, spdt_s1_d, spdt_s2_q, spdt_s2_d;
    logic        spdt_prev_q, spdt_prev_d;
    logic        pend_q, pend_d;   // spdt1 rise seen during COMMIT, replayed in IDLE
    logic        spdt_rise;
    action_e     act;

    assign spdt_rise = spdt_s2_q & ~spdt_prev_q;
    assign act       = pick_action(btn_pulse);

    // Next state, value and selection
    always_comb begin
        state_d     = state_q;
        num_d       = num_q;
        sel_d       = sel_q;
        pend_d      = pend_q;
        spdt_s1_d   = spdt1;
        spdt_s2_d   = spdt_s1_q;
        spdt_prev_d = spdt_s2_q;
        case (state_q)
            IDLE: begin
                sel_d  = '0;
                pend_d = 1'b0;
                if (spdt_rise || pend_q) begin
                    num_d   = preset;
                    sel_d   = SEL_LEFTMOST;
                    state_d = EDIT;
                end
            end
            EDIT: begin
                if (!spdt_s2_q) begin
                    state_d = COMMIT;
                end else begin
                    case (act)
                        ACT_UP:    num_d = bump_digit(num_q, sel_q, 1'b1);
                        ACT_DOWN:  num_d = bump_digit(num_q, sel_q, 1'b0);
                        ACT_LEFT:  sel_d = {sel_q[2:0], sel_q[3]};
                        ACT_RIGHT: sel_d = {sel_q[0], sel_q[3:1]};
                        default:   ;
                    endcase
                end
            end
            COMMIT: begin
                sel_d   = '0;
                state_d = IDLE;
                if (spdt_rise) pend_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
                sel_d   = '0;
            end
        endcase
    end

    // State, value and spdt1 synchronizer registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            num_q       <= '0;
            sel_q       <= '0;
            pend_q      <= 1'b0;
            spdt_s1_q   <= 1'b0;
            spdt_s2_q   <= 1'b0;
            spdt_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_q       <= num_d;
            sel_q       <= sel_d;
            pend_q      <= pend_d;
            spdt_s1_q   <= spdt_s1_d;
            spdt_s2_q   <= spdt_s2_d;
            spdt_prev_q <= spdt_prev_d;
        end
    end

    assign num     = num_q;
    assign sel     = sel_q;
    assign finish1 = (state_q == COMMIT);

endmodule

// File: tb/tb_time_set_editor.sv
// Directed, table-driven bench for time_set_editor.
module tb_time_set_editor;

`ifdef TIME_SET_DEBOUNCE_EN
    localparam int DB = 16;
`else
    localparam int DB = 0;
`endif
    localparam int LAT  = 3 + DB;
    localparam int HOLD = LAT + 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        spdt1 = 1'b0;
    logic [15:0] preset = 16'h0000;
    logic        push_u = 1'b0, push_d = 1'b0, push_l = 1'b0, push_r = 1'b0;
    logic [15:0] num;
    logic [3:0]  sel;
    logic        finish1;

    int checks = 0;
    int errors = 0;

    time_set_editor #(.DEBOUNCE_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .spdt1(spdt1), .preset(preset),
        .push_u(push_u), .push_d(push_d), .push_l(push_l), .push_r(push_r),
        .num(num), .sel(sel), .finish1(finish1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  btns;     // {u,d,l,r}
        logic [15:0] exp_num;
        logic [3:0]  exp_sel;
    } vec_t;

    vec_t vecs [31];

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic press(input logic [3:0] b);
        {push_u, push_d, push_l, push_r} = b;
        step(HOLD);
        {push_u, push_d, push_l, push_r} = 4'b0000;
        step(HOLD);
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            press(vecs[i].btns);
            check($sformatf("vec%0d num", i), 32'(num), 32'(vecs[i].exp_num));
            check($sformatf("vec%0d sel", i), 32'(sel), 32'(vecs[i].exp_sel));
        end
    endtask

    initial begin
        int pulses;
        // session 1 from 2234 at sel 1000
        vecs[0]  = '{4'b1000, 16'h3234, 4'b1000};
        vecs[1]  = '{4'b1000, 16'h4234, 4'b1000};
        vecs[2]  = '{4'b1000, 16'h5234, 4'b1000};
        vecs[3]  = '{4'b1000, 16'h0234, 4'b1000};
        vecs[4]  = '{4'b0100, 16'h5234, 4'b1000};
        vecs[5]  = '{4'b0001, 16'h5234, 4'b0100};
        vecs[6]  = '{4'b0100, 16'h5134, 4'b0100};
        vecs[7]  = '{4'b0100, 16'h5034, 4'b0100};
        vecs[8]  = '{4'b0100, 16'h5934, 4'b0100};
        vecs[9]  = '{4'b1000, 16'h5034, 4'b0100};
        vecs[10] = '{4'b0001, 16'h5034, 4'b0010};
        vecs[11] = '{4'b1000, 16'h5044, 4'b0010};
        vecs[12] = '{4'b1000, 16'h5054, 4'b0010};
        vecs[13] = '{4'b1000, 16'h5004, 4'b0010};
        vecs[14] = '{4'b0001, 16'h5004, 4'b0001};
        vecs[15] = '{4'b1000, 16'h5005, 4'b0001};
        vecs[16] = '{4'b0100, 16'h5004, 4'b0001};
        vecs[17] = '{4'b0001, 16'h5004, 4'b1000};
        vecs[18] = '{4'b0010, 16'h5004, 4'b0001};
        vecs[19] = '{4'b0010, 16'h5004, 4'b0010};
        vecs[20] = '{4'b1010, 16'h5014, 4'b0010};
        vecs[21] = '{4'b0101, 16'h5004, 4'b0010};
        vecs[22] = '{4'b0011, 16'h5004, 4'b0100};
        vecs[23] = '{4'b1100, 16'h5104, 4'b0100};
        // session 2 from out-of-range preset F9AB
        vecs[24] = '{4'b1000, 16'h09AB, 4'b1000};
        vecs[25] = '{4'b0001, 16'h09AB, 4'b0100};
        vecs[26] = '{4'b0100, 16'h08AB, 4'b0100};
        vecs[27] = '{4'b0001, 16'h08AB, 4'b0010};
        vecs[28] = '{4'b0100, 16'h085B, 4'b0010};
        vecs[29] = '{4'b0001, 16'h085B, 4'b0001};
        vecs[30] = '{4'b1000, 16'h0850, 4'b0001};

        // reset state
        step(2);
        check("reset num", 32'(num), 32'h0000);
        check("reset sel", 32'(sel), 32'h0);
        check("reset finish1", 32'(finish1), 32'h0);
        reset = 1'b0;
        step(2);

        // spdt1 rise: EDIT exactly 3 edges later with preset loaded
        preset = 16'h1234;
        spdt1  = 1'b1;
        step(2);
        check("enter early sel", 32'(sel), 32'h0);
        step(1);
        check("enter num", 32'(num), 32'h1234);
        check("enter sel", 32'(sel), 32'h8);
        check("enter finish1", 32'(finish1), 32'h0);

        // button-to-action latency
        push_u = 1'b1;
        step(LAT - 1);
        check("lat early num", 32'(num), 32'h1234);
        step(1);
        check("lat num", 32'(num), 32'h2234);
        step(HOLD);
        check("hold no repeat", 32'(num), 32'h2234);
        push_u = 1'b0;
        step(HOLD);

        run_vecs(0, 23);

        // commit: finish1 exactly 3 edges after spdt1 falls, one cycle wide
        spdt1 = 1'b0;
        step(2);
        check("commit early finish1", 32'(finish1), 32'h0);
        step(1);
        check("commit finish1", 32'(finish1), 32'h1);
        check("commit num", 32'(num), 32'h5104);
        step(1);
        check("commit end finish1", 32'(finish1), 32'h0);
        check("commit end sel", 32'(sel), 32'h0);
        check("commit end num", 32'(num), 32'h5104);

        // buttons ignored in IDLE
        press(4'b1000);
        check("idle num", 32'(num), 32'h5104);
        check("idle sel", 32'(sel), 32'h0);

        // out-of-range preset
        preset = 16'hF9AB;
        spdt1  = 1'b1;
        step(3);
        check("oor load num", 32'(num), 32'hF9AB);
        run_vecs(24, 30);

        // spdt1 low for one cycle then high: commit, then reload new preset
        preset = 16'h0317;
        spdt1  = 1'b0;
        step(1);
        spdt1  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (finish1) pulses++;
        end
        check("toggle pulses", 32'(pulses), 32'd1);
        check("toggle num", 32'(num), 32'h0317);
        check("toggle sel", 32'(sel), 32'h8);

`ifdef TIME_SET_DEBOUNCE_EN
        // 10-cycle glitch rejected
        push_u = 1'b1;
        step(10);
        push_u = 1'b0;
        step(40);
        check("glitch num", 32'(num), 32'h0317);
        // 40-cycle press: one increment, 19 edges after the press
        push_u = 1'b1;
        step(18);
        check("db early num", 32'(num), 32'h0317);
        step(1);
        check("db num", 32'(num), 32'h1317);
        step(21);
        push_u = 1'b0;
        step(40);
        check("db single num", 32'(num), 32'h1317);
`endif

        // reset mid-EDIT: no commit pulse, back to reset values
        reset = 1'b1;
        spdt1 = 1'b0;
        step(1);
        check("midreset num", 32'(num), 32'h0000);
        check("midreset sel", 32'(sel), 32'h0);
        reset  = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (finish1) pulses++;
        end
        check("midreset pulses", 32'(pulses), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
